// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Default fetch widths, the FSM state encoding and the NOP word.
package fetch_pkg;

    localparam int FETCH_AW = 8;
    localparam int FETCH_DW = 32;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program-counter register: load has priority over increment.
// The increment wraps modulo 2^AW with no flag.
module fetch_pc_reg #(
    parameter int              AW       = 8,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [AW-1:0] load_addr,
    input  logic          inc,
    output logic [AW-1:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_addr;
        end else if (inc) begin
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, run/halt FSM and IF/ID output register.
// Define FETCH_HALT_ON_ZERO_EN to treat a zero word as end-of-program.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int            AW       = FETCH_AW,
    parameter int            DW       = FETCH_DW,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          halt,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_addr,
    output logic [AW-1:0] imem_addr,
    input  logic [DW-1:0] imem_rd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_instr,
    output logic [AW-1:0] out_pc,
    output logic [1:0]    state_o
);

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] pc;
    logic          can_load;
    logic          fetch;

    assign can_load  = !out_valid || out_ready;
    assign imem_addr = pc;
    assign state_o   = state_q;

    fetch_pc_reg #(
        .AW       (AW),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (redirect_valid),
        .load_addr (redirect_addr),
        .inc       (fetch),
        .pc        (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fetch   = 1'b0;
        case (state_q)
            IDLE, HALT: begin
                if (!redirect_valid && !halt && start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!redirect_valid) begin
                    if (halt) begin
                        state_d = HALT;
                    end else if (can_load) begin
`ifdef FETCH_HALT_ON_ZERO_EN
                        // zero word stops here; PC stays on it
                        if (imem_rd == DW'(NOP_WORD)) begin
                            state_d = HALT;
                        end else begin
                            fetch = 1'b1;
                        end
`else
                        fetch = 1'b1;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
        end else if (redirect_valid) begin
            out_valid <= 1'b0;
        end else if (fetch) begin
            out_valid <= 1'b1;
            out_instr <= imem_rd;
            out_pc    <= pc;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit.
// Delivered stream is checked against a PC-sequence model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, halt, redirect_valid, out_ready;
    logic [7:0]  redirect_addr, imem_addr, out_pc;
    logic [31:0] imem_rd, out_instr;
    logic        out_valid;
    logic [1:0]  state_o;

    logic        fe_start, fe_halt;
    logic [7:0]  fe_addr, fe_pc;
    logic [31:0] fe_rd, fe_instr;
    logic        fe_valid;
    logic [1:0]  fe_state;

    logic [31:0] mem [256];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_rd = mem[imem_addr];
    assign fe_rd   = mem[fe_addr];

    fetch_unit u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .imem_addr      (imem_addr),
        .imem_rd        (imem_rd),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .state_o        (state_o)
    );

    fetch_unit #(.RESET_PC(8'hFE)) u_fe (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (fe_start),
        .halt           (fe_halt),
        .redirect_valid (1'b0),
        .redirect_addr  (8'h00),
        .imem_addr      (fe_addr),
        .imem_rd        (fe_rd),
        .out_valid      (fe_valid),
        .out_ready      (1'b1),
        .out_instr      (fe_instr),
        .out_pc         (fe_pc),
        .state_o        (fe_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp_pc;
        logic [7:0] raddr;
        logic       redir;
        int         nxfer;

        rst_n = 1'b0;
        start = 0; halt = 0; redirect_valid = 0;
        redirect_addr = 0; out_ready = 0;
        fe_start = 0; fe_halt = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0] = 32'h200100CA;
        for (int i = 1; i <= 4; i++) mem[i] = 32'h00210820;
        mem[8'h10] = 32'hDEADBEEF;
        mem[8'h11] = 32'h11111111;
        mem[8'hFE] = 32'hFEFEFEFE;
        mem[8'hFF] = 32'hFFFFFFFF;
        tick();
        tick();

        chk("rst_state", state_o, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_instr", out_instr, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_fe_addr", fe_addr, 8'hFE);
        rst_n = 1'b1;
        tick();

        // wrap from a non-zero reset PC
        fe_start = 1;
        tick();
        fe_start = 0;
        chk("fe_run_nofetch", fe_valid, 0);
        tick();
        chk("fe_pc0", fe_pc, 8'hFE);
        chk("fe_instr0", fe_instr, 32'hFEFEFEFE);
        tick();
        chk("fe_pc1", fe_pc, 8'hFF);
        tick();
        chk("fe_pc2", fe_pc, 8'h00);
        chk("fe_instr2", fe_instr, 32'h200100CA);
        fe_halt = 1;
        tick();
        fe_halt = 0;
        chk("fe_halted", fe_state, 2);

        // basic stream
        out_ready = 1;
        start = 1;
        tick();
        start = 0;
        chk("t1_state", state_o, 1);
        chk("t1_nofetch", out_valid, 0);
        chk("t1_addr", imem_addr, 0);
        tick();
        chk("t1_v0", out_valid, 1);
        chk("t1_i0", out_instr, 32'h200100CA);
        chk("t1_p0", out_pc, 0);
        chk("t1_a0", imem_addr, 1);
        tick();
        chk("t1_p1", out_pc, 1);
        chk("t1_i1", out_instr, 32'h00210820);

        // backpressure
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_hold_pc", out_pc, 1);
            chk("t2_hold_v", out_valid, 1);
            chk("t2_hold_a", imem_addr, 2);
        end
        out_ready = 1;
        tick();
        chk("t2_p2", out_pc, 2);
        tick();
        chk("t2_p3", out_pc, 3);

        // redirect
        redirect_valid = 1;
        redirect_addr  = 8'h10;
        tick();
        redirect_valid = 0;
        chk("t3_flush", out_valid, 0);
        chk("t3_addr", imem_addr, 8'h10);
        tick();
        chk("t3_v", out_valid, 1);
        chk("t3_pc", out_pc, 8'h10);
        chk("t3_instr", out_instr, 32'hDEADBEEF);

        // halt beats start
        halt = 1;
        start = 1;
        tick();
        halt = 0;
        start = 0;
        chk("t5_state", state_o, 2);
        chk("t5_drain", out_valid, 0);
        chk("t5_addr", imem_addr, 8'h11);
        tick();
        tick();
        chk("t5_still", state_o, 2);
        chk("t5_nofetch", out_valid, 0);
        start = 1;
        tick();
        start = 0;
        chk("t5_run", state_o, 1);
        chk("t5_nofetch2", out_valid, 0);
        tick();
        chk("t5_pc", out_pc, 8'h11);
        chk("t5_instr", out_instr, 32'h11111111);

        // zero-word behaviour
        redirect_valid = 1;
        redirect_addr  = 8'h00;
        tick();
        redirect_valid = 0;
        chk("t6_flush", out_valid, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6_pc", out_pc, i);
            chk("t6_instr", out_instr, mem[i]);
        end
        tick();
`ifdef FETCH_HALT_ON_ZERO_EN
        chk("t6_halt", state_o, 2);
        chk("t6_valid", out_valid, 0);
        chk("t6_addr", imem_addr, 5);
        start = 1;
        tick();
        start = 0;
`else
        chk("t6_pc5", out_pc, 5);
        chk("t6_nop", out_instr, 32'h0);
        chk("t6_v5", out_valid, 1);
`endif

        // randomized stream against the PC-sequence model
        redirect_valid = 1;
        redirect_addr  = 8'($urandom);
        tick();
        redirect_valid = 0;
        exp_pc = redirect_addr;
        for (int i = 0; i < 256; i++) mem[i] = $urandom | 32'h1;
        nxfer = 0;
        for (int c = 0; c < 600; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 15) == 0);
            raddr = 8'($urandom);
            redirect_valid = redir;
            redirect_addr  = raddr;
            halt  = ($urandom_range(0, 19) == 0);
            start = ($urandom_range(0, 7) == 0);
            if (out_valid && out_ready) begin
                chk("rnd_pc", out_pc, exp_pc);
                chk("rnd_instr", out_instr, mem[exp_pc]);
                exp_pc = exp_pc + 8'd1;
                nxfer++;
            end
            if (redir) exp_pc = raddr;
            tick();
        end
        redirect_valid = 0;
        halt = 0;
        start = 0;
        checks++;
        assert (nxfer > 100) else begin
            errors++;
            $error("FAIL rnd_progress: got %0d want >100", nxfer);
        end

        // asynchronous reset mid-stream
        out_ready = 1;
        start = 1;
        tick();
        start = 0;
        tick();
        tick();
        chk("ar_pre_valid", out_valid, 1);
        rst_n = 1'b0;
        #2;
        chk("ar_valid", out_valid, 0);
        chk("ar_instr", out_instr, 0);
        chk("ar_pc", out_pc, 0);
        chk("ar_state", state_o, 0);
        chk("ar_addr", imem_addr, 0);
        chk("ar_fe_addr", fe_addr, 8'hFE);
        tick();
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
